sysbus_arbiter: RTL

Round-robin arbiter that shares the single main system bus among up to NUM_REQ bus masters (icache fill, dcache fill/writeback, invalidation/evict snooper, ...). Each master raises `abtr_reqcyc`, waits for its grant bit, then holds `bus_busy` for the duration of its bus transaction. The arbiter serializes ownership, enforces a one-cycle turnaround between owners and flags masters that never take or never release the bus. It sits between the masters' arbitration handshake and the top-level bus mux, which it drives through `owner_id`.

---
 rtl/sysbus_arb_pkg.sv | 16 +
 rtl/sysbus_arbiter_if.sv | 35 +++
 rtl/rr_pick.sv | 40 ++++
 rtl/sysbus_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/sysbus_arb_pkg.sv
// Shared definitions for the system-bus arbiter: FSM state encoding and
// default timing limits used by the arbiter, the bus mux and master benches.
package sysbus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        OWNED   = 2'b10,
        RELEASE = 2'b11
    } arb_state_e;

    localparam int unsigned DEF_NUM_REQ       = 4;
    localparam int unsigned DEF_GRANT_TIMEOUT = 16;
    localparam int unsigned DEF_HOLD_MAX      = 1024;

endpackage

// File: rtl/sysbus_arbiter_if.sv
// Arbitration handshake between the bus masters and the system-bus arbiter.
interface sysbus_arbiter_if #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
);

    logic [NUM_REQ-1:0]  abtr_reqcyc;
    logic [NUM_REQ-1:0]  bus_busy;
    logic [NUM_REQ-1:0]  abtr_grant;
    logic                owner_valid;
    logic [ID_WIDTH-1:0] owner_id;
    logic                grant_timeout;
    logic                hold_err;

    modport master (
        output abtr_reqcyc,
        output bus_busy,
        input  abtr_grant,
        input  owner_valid,
        input  owner_id,
        input  grant_timeout,
        input  hold_err
    );

    modport slave (
        input  abtr_reqcyc,
        input  bus_busy,
        output abtr_grant,
        output owner_valid,
        output owner_id,
        output grant_timeout,
        output hold_err
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate requests so the master after
// last_owner sits at bit 0, priority-encode, then un-rotate the index.
module rr_pick #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last_owner,
    output logic [NUM_REQ-1:0]  win_onehot_c,
    output logic [ID_WIDTH-1:0] win_idx_c,
    output logic                any_c
);

    logic [ID_WIDTH-1:0] start;
    logic [NUM_REQ-1:0]  rot;
    logic [ID_WIDTH-1:0] enc;
    int unsigned         sum;

    always_comb begin
        start = (last_owner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : last_owner + ID_WIDTH'(1);

        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rot[i] = req[ID_WIDTH'((i + 32'(start)) % NUM_REQ)];
        end

        // Descending scan leaves the lowest rotated set bit in enc.
        enc = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                enc = ID_WIDTH'(i);
            end
        end

        sum          = 32'(enc) + 32'(start);
        win_idx_c    = ID_WIDTH'(sum % NUM_REQ);
        any_c        = |req;
        win_onehot_c = any_c ? (NUM_REQ'(1) << win_idx_c) : '0;
    end

endmodule

// File: rtl/sysbus_arbiter.sv
// Round-robin owner arbitration for the main system bus with one-cycle
// turnaround, grant timeout and sticky over-long ownership detection.
module sysbus_arbiter
    import sysbus_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = DEF_NUM_REQ,
    parameter int unsigned GRANT_TIMEOUT = DEF_GRANT_TIMEOUT,
    parameter int unsigned HOLD_MAX      = DEF_HOLD_MAX,
    parameter int unsigned ID_WIDTH      = $clog2(NUM_REQ)
) (
    input logic             clk,
    input logic             reset,
    sysbus_arbiter_if.slave bus
);

    localparam int unsigned WAIT_W = $clog2(GRANT_TIMEOUT + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_MAX + 1);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                owner_valid_q, owner_valid_d;
    logic [ID_WIDTH-1:0] owner_id_q, owner_id_d;
    logic [ID_WIDTH-1:0] last_owner_q, last_owner_d;
    logic                grant_timeout_q, grant_timeout_d;
    logic                hold_err_q, hold_err_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

    logic [NUM_REQ-1:0]  win_onehot_c;
    logic [ID_WIDTH-1:0] win_idx_c;
    logic                any_c;

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_pick (
        .req          (bus.abtr_reqcyc),
        .last_owner   (last_owner_q),
        .win_onehot_c (win_onehot_c),
        .win_idx_c    (win_idx_c),
        .any_c        (any_c)
    );

    // Next-state and registered-output computation.
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        owner_valid_d   = owner_valid_q;
        owner_id_d      = owner_id_q;
        last_owner_d    = last_owner_q;
        grant_timeout_d = 1'b0;
        hold_err_d      = hold_err_q;
        wait_cnt_d      = wait_cnt_q;
        hold_cnt_d      = hold_cnt_q;

        case (state_q)
            IDLE: begin
                if (any_c) begin
                    state_d       = GRANT;
                    grant_d       = win_onehot_c;
                    owner_id_d    = win_idx_c;
                    owner_valid_d = 1'b1;
                    wait_cnt_d    = '0;
                end
            end
            GRANT: begin
                if (bus.bus_busy[owner_id_q]) begin
                    state_d    = OWNED;
                    hold_cnt_d = '0;
                end else if (!bus.abtr_reqcyc[owner_id_q]) begin
                    state_d       = RELEASE;
                    grant_d       = '0;
                    owner_valid_d = 1'b0;
                end else if (wait_cnt_q >= WAIT_W'(GRANT_TIMEOUT - 1)) begin
                    state_d         = RELEASE;
                    grant_d         = '0;
                    owner_valid_d   = 1'b0;
                    grant_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            OWNED: begin
                // A transaction in flight cannot be aborted, so overrun is only flagged.
                if (!bus.bus_busy[owner_id_q]) begin
                    state_d       = RELEASE;
                    grant_d       = '0;
                    owner_valid_d = 1'b0;
                end else begin
                    if (hold_cnt_q < HOLD_W'(HOLD_MAX)) begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                    if (hold_cnt_q >= HOLD_W'(HOLD_MAX - 1)) begin
                        hold_err_d = 1'b1;
                    end
                end
            end
            RELEASE: begin
                state_d      = IDLE;
                last_owner_d = owner_id_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; last_owner resets so master 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            grant_q         <= '0;
            owner_valid_q   <= 1'b0;
            owner_id_q      <= '0;
            last_owner_q    <= ID_WIDTH'(NUM_REQ - 1);
            grant_timeout_q <= 1'b0;
            hold_err_q      <= 1'b0;
            wait_cnt_q      <= '0;
            hold_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            owner_valid_q   <= owner_valid_d;
            owner_id_q      <= owner_id_d;
            last_owner_q    <= last_owner_d;
            grant_timeout_q <= grant_timeout_d;
            hold_err_q      <= hold_err_d;
            wait_cnt_q      <= wait_cnt_d;
            hold_cnt_q      <= hold_cnt_d;
        end
    end

    assign bus.abtr_grant    = grant_q;
    assign bus.owner_valid   = owner_valid_q;
    assign bus.owner_id      = owner_id_q;
    assign bus.grant_timeout = grant_timeout_q;
    assign bus.hold_err      = hold_err_q;

endmodule
